// File: rtl/dsp_cfg_pkg.sv
// Shared types and defaults for the PIRDSP serial configuration loader.
// ERR state exists only when DSP_CFG_PARITY_EN is defined.
package dsp_cfg_pkg;

  localparam int DSP_CFG_WIDTH_DEF  = 32;
  localparam int DSP_CFG_SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SETTLE = 3'd2,
    DONE   = 3'd3
`ifdef DSP_CFG_PARITY_EN
    ,
    ERR    = 3'd4
`endif
  } cfg_state_t;

  function automatic int cfg_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dsp_cfg_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter.
// 'last' is high while the final bit is presented.
module dsp_cfg_shifter
  import dsp_cfg_pkg::*;
#(
  parameter int WIDTH = DSP_CFG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word,
  output logic             msb,
  output logic             last
);

  localparam int CNT_W = cfg_cnt_w(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = word;
      cnt_d  = CNT_W'(WIDTH - 1);
    end else if (shift) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign msb  = sreg_q[WIDTH-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/dsp_cfg_loader.sv
// Serial configuration loader for the PIRDSP MF2 slice: valid/ready word in, MSB-first chain out.
// Optional even-parity rejection is enabled by defining DSP_CFG_PARITY_EN.
module dsp_cfg_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CFG_WIDTH     = DSP_CFG_WIDTH_DEF,
  parameter int SETTLE_CYCLES = DSP_CFG_SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CFG_WIDTH-1:0] cfg_word,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
`ifdef DSP_CFG_PARITY_EN
  input  logic                 cfg_parity,
`endif
  output logic                 configuration_input,
  output logic                 configuration_enable,
  output logic                 dsp_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int SET_W = (SETTLE_CYCLES > 0) ? cfg_cnt_w(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  cfg_state_t       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic ready_q, ready_d, enable_q, enable_d, hold_q, hold_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic accept, msb, last;

  assign accept = cfg_valid & ready_q;

`ifdef DSP_CFG_PARITY_EN
  logic reject;
  assign reject = cfg_parity ^ (^cfg_word);
`endif

  dsp_cfg_shifter #(
    .WIDTH(CFG_WIDTH)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(state_q == SHIFT),
    .word (cfg_word),
    .msb  (msb),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ready_q  <= ready_d;
      enable_q <= enable_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DSP_CFG_PARITY_EN
          state_d = reject ? ERR : SHIFT;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (last) begin
          state_d  = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = DONE;
        else                settle_d = settle_q - SET_W'(1);
      end
      DONE:    state_d = IDLE;
`ifdef DSP_CFG_PARITY_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    ready_d  = (state_d == IDLE);
    enable_d = (state_d == SHIFT);
    hold_d   = (state_d == SHIFT) || (state_d == SETTLE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
`ifdef DSP_CFG_PARITY_EN
    err_d    = (state_d == ERR);
`else
    err_d    = 1'b0;
`endif
  end

  assign cfg_ready            = ready_q;
  assign configuration_enable = enable_q;
  assign configuration_input  = enable_q & msb;
  assign dsp_hold             = hold_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign err                  = err_q;

endmodule

// File: doc/dsp_cfg_loader.md
# dsp_cfg_loader

Serial configuration loader for the PIRDSP proposed-MF2 DSP slice. It accepts one parallel configuration word per valid/ready handshake and shifts it MSB-first into the slice's `configuration_input` / `configuration_enable` chain. It then waits a fixed settle interval to cover the slice's input register stage, and signals completion. While loading it holds `dsp_hold` high so the surrounding datapath can gate the slice clock enables.

## Interface
- `CFG_WIDTH`, 32: configuration word width in bits; legal range 2..256.
- `SETTLE_CYCLES`, 2: idle cycles after the last shifted bit before `done`; legal range 0..15.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `cfg_word`  in  CFG_WIDTH  configuration word to load.
- `cfg_valid`  in  1  `cfg_word` is valid.
- `cfg_ready`  out  1  loader can accept a word; high only in IDLE.
- `cfg_parity`  in  1  even-parity bit over `cfg_word`; present only with `DSP_CFG_PARITY_EN`.
- `configuration_input`  out  1  serial config data to the DSP slice.
- `configuration_enable`  out  1  serial shift enable to the DSP slice.
- `dsp_hold`  out  1  high during SHIFT and SETTLE; the datapath deasserts slice CE* while it is high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle parity-reject pulse; tied 0 without the macro.

## Operation
- States: IDLE, SHIFT, SETTLE, DONE, and ERR (macro only).
- IDLE:
  - `cfg_ready`=1.
  - When `cfg_valid`&`cfg_ready`, capture `cfg_word` into the shift register and load the bit counter with CFG_WIDTH-1.
  - Then go to SHIFT, or to ERR on a parity failure.
- SHIFT:
  - `configuration_enable`=1 and `configuration_input`=sreg[CFG_WIDTH-1].
  - Each cycle, shift sreg left by 1 with zero fill and decrement the counter.
  - When the counter is 0, go to SETTLE, or to DONE if SETTLE_CYCLES=0.
- SETTLE:
  - `configuration_enable`=0 and `configuration_input`=0.
  - Count SETTLE_CYCLES cycles, then go to DONE.
- DONE:
  - `done`=1 and `dsp_hold`=0 for one cycle, then go to IDLE.
- `cfg_valid` is ignored while not in IDLE. No word is queued or lost silently; the requester holds the word until `cfg_ready`.
- Outside SHIFT, `configuration_input` is driven 0.
- Reset values of all outputs: `cfg_ready`=0 while `rst` is high, then 1 in the first IDLE cycle. `configuration_input`=0, `configuration_enable`=0, `dsp_hold`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-SHIFT: the chain is left partially loaded and no `done` is issued. The requester must reissue the full word.

## Timing
- Handshake accepted at rising edge T. `cfg_ready` falls after T.
- Cycles T+1 .. T+CFG_WIDTH: SHIFT, with `configuration_enable`=1. Bit i of the sequence, counting from the MSB, appears in cycle T+1+i.
- Cycles T+CFG_WIDTH+1 .. T+CFG_WIDTH+SETTLE_CYCLES: SETTLE.
- Cycle T+CFG_WIDTH+SETTLE_CYCLES+1: DONE, with the `done` pulse.
- The next acceptance can occur at the earliest at T+CFG_WIDTH+SETTLE_CYCLES+2. Total load period is CFG_WIDTH+SETTLE_CYCLES+2 cycles.
- `dsp_hold` is exactly high from T+1 through the last SETTLE cycle.
- All outputs are registered; no output depends combinationally on any input.

## Configuration
- Macro: `DSP_CFG_PARITY_EN`.
- Defined:
  - The `cfg_parity` port exists. A word is rejected when `cfg_parity ^ (^cfg_word)` is 1.
  - On reject, the handshake still completes. The FSM enters ERR for one cycle with `err`=1 and `busy`=1. Nothing is shifted and `dsp_hold` stays 0.
  - FSM then returns to IDLE.
- Undefined: the port is absent, there is no ERR state, and `err` is tied 0.

## Structure
- Package `dsp_cfg_pkg` holds:
  - State enum `cfg_state_t`.
  - Default constants `DSP_CFG_WIDTH_DEF`=32 and `DSP_CFG_SETTLE_DEF`=2.
  - Counter width function `cfg_cnt_w(n)`=$clog2(n+1).
- Sub-module `dsp_cfg_shifter` holds the parallel-load shift register and bit counter, with `load`, `shift` and `last` signals.
- The top level holds the FSM, settle counter and handshake logic.

## Test plan
- **Basic load:** rst, then `cfg_word`=32'hA5A5_0F0F with valid. Serial stream is 1010_0101_1010_0101_0000_1111_0000_1111 over 32 enable cycles. `done` pulses at T+35 and `cfg_ready` returns at T+36.
- **Back-to-back:** `cfg_valid` held high with two words 32'h1 and 32'h8000_0000. Second acceptance happens exactly 36 cycles after the first. Streams are 31 zeros then 1, and 1 then 31 zeros.
- **Reset mid-shift:** rst asserted in SHIFT cycle 10. All outputs are 0 asynchronously, no `done`, and a fresh load then completes normally.
- **SETTLE_CYCLES=0, CFG_WIDTH=2:** word 2'b10. Enable is high for 2 cycles with data 1,0, and `done` pulses at T+3.
- **`cfg_valid` during busy:** pulse `cfg_valid` with a new word at T+5. It is ignored, and the shifted stream equals the first word.
- **Parity (macro on):** word 32'h1 with `cfg_parity`=0. `err` pulses at T+1, `configuration_enable` stays 0 and `dsp_hold` stays 0. The same word with `cfg_parity`=1 loads normally.
